seqdet_ctrl: RTL and testbench
==============================

# seqdet_ctrl

Frame controller for the serial sequence detector. It accepts parallel words over a valid/ready handshake and clears the detector at frame start. It then serialises each word MSB-first onto the detector's `x` input with a qualifying strobe, and counts the detector's `z` hits over the frame. It reports the count with a one-cycle done pulse. It sits between a word-oriented producer and a single detector instance.

## Interface
- `W`, 8, word width in bits (≥2)
- `CNT_W`, 8, hit counter width; the counter saturates at 2^CNT_W−1

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  producer has a word
- `in_data`  in  W  word to serialise
- `in_last`  in  1  qualifies `in_data` as the final word of the frame
- `in_ready`  out  1  controller accepts a word this cycle
- `det_clr`  out  1  one-cycle synchronous clear to the detector, registered
- `det_vld`  out  1  `det_x` carries a valid bit; detector wrapper uses it as clock enable; registered
- `det_x`  out  1  serial bit to the detector, registered
- `det_z`  in  1  detector match output; Moore, valid the cycle after the bit that caused it
- `hit_count`  out  CNT_W  hits in the current or most recent frame
- `done`  out  1  one-cycle pulse: frame complete, `hit_count` final
- `busy`  out  1  state ≠ IDLE

## Operation
- **States:** IDLE, CLR, SHIFT, WAIT, DRAIN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On accept: load the shift register with `in_data`, latch `in_last`, go to CLR.
- **CLR** (1 cycle)
  - `det_clr`=1, `det_vld`=0.
  - `hit_count`←0.
  - Go to SHIFT.
- **SHIFT**
  - Each cycle, `det_vld`=1 and `det_x` = current MSB; shift left; bit index counts W−1→0.
  - `in_ready`=1 only in the final-bit cycle, and only when the latched last flag is 0.
  - On the final bit:
    - last=1 → DRAIN.
    - last=0 and accept → reload and stay in SHIFT, with no gap.
    - last=0 and no accept → WAIT.
- **WAIT**
  - `in_ready`=1, `det_vld`=0, `det_x`=0.
  - On accept: load, latch `in_last`, go to SHIFT. There is no detector clear, so detector state carries across the gap.
- **DRAIN** (1 cycle): samples `det_z` for the final bit, then goes to DONE.
- **DONE** (1 cycle): `done`=1, then go to IDLE.
- **Hit sampling**
  - `vld_d` is a register copy of `det_vld`.
  - `hit_count` increments on every edge where `vld_d`=1 and `det_z`=1.
  - Increment saturates; no wrap.
  - `hit_count` holds its value from DONE until the next CLR.
- **Input handshake:** `in_data`/`in_last` are ignored when `in_ready`=0. `in_valid` may stay high without effect.

## Timing
- **Reset (async, `rst`=0):**
  - State → IDLE.
  - `det_clr`=`det_vld`=`det_x`=`done`=0; `hit_count`=0; `busy`=0; `in_ready`=1 (decoded from state).
  - Reset mid-frame abandons the frame; no `done` is produced.
- **Single-word frame, accepted at edge k:**
  - CLR in cycle k+1.
  - Bits in cycles k+2…k+1+W.
  - DRAIN in cycle k+2+W.
  - `done` in cycle k+3+W with final `hit_count`.
  - Frame latency is W+3 cycles from accept to `done`.
- **Back-to-back words:** the next word's MSB follows the previous LSB in the very next cycle. An N-word frame fed continuously completes `done` N·W+3 cycles after the first accept.
- **Next frame:** the earliest new accept is the first IDLE cycle after DONE, a 1-cycle gap.
- **Simultaneous events:**
  - A `det_z` hit in the same cycle as CLR is ignored, because `vld_d`=0 and the counter is cleared.
  - A hit sampled during the DRAIN edge is counted before DONE.

## Test plan
The bench detector model drives `det_z` = registered (`det_x` & `det_vld`), so hits equal the popcount of the transmitted bits. W=8, CNT_W=8.

- **Single word:** accept 0xA5 with last=1 at edge k → `det_clr` at k+1; `det_x` = 1,0,1,0,0,1,0,1 in cycles k+2..k+9; `done` at k+11 with `hit_count`=4.
- **Back-to-back:** 0xFF then 0x0F (last), `in_valid` held high → 16 contiguous `det_vld` cycles; `in_ready` high only in IDLE and the 8th bit cycle; `done` with `hit_count`=12.
- **Producer gap:** 0x80, then 5 idle cycles, then 0x01 (last) → WAIT for 5 cycles with `det_vld`=0 and no `det_clr`; `hit_count`=2.
- **Saturation:** 40 words of 0xFF, the last flagged → 320 hits; `hit_count`=255, no wrap.
- **Reset mid-frame:** `rst` low during bit 4 of the first word → all outputs at reset values immediately. A new 0x03 frame afterwards gives `hit_count`=2 with nothing carried over.
- **Stall ignore:** toggle `in_data` while `in_valid`=1 and `in_ready`=0 in SHIFT → the serial output is unchanged.

Source files
------------

// File: rtl/seqdet_ctrl.sv
// Frame controller for the serial sequence detector: clears the detector at frame
// start, serialises words MSB-first with a valid strobe and counts detector hits.
module seqdet_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic [W-1:0]     i_in_data,
    input  logic             i_in_last,
    output logic             o_in_ready,
    output logic             o_det_clr,
    output logic             o_det_vld,
    output logic             o_det_x,
    input  logic             i_det_z,
    output logic [CNT_W-1:0] o_hit_count,
    output logic             o_done,
    output logic             o_busy
);
    localparam int               IDX_W   = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_shift;
    logic [W-1:0]     w_shift_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_det_clr;
    logic             r_det_vld;
    logic             r_det_x;
    logic             r_vld_d;
    logic             r_done;
    logic [CNT_W-1:0] r_hit_count;
    logic             w_ready;
    logic             w_accept;
    logic             w_final_bit;

    assign w_final_bit = (r_idx == '0);
    assign w_ready     = (r_state == S_IDLE) || (r_state == S_WAIT) ||
                         ((r_state == S_SHIFT) && w_final_bit && !r_last);
    assign w_accept    = i_in_valid && w_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // A reload on the final bit keeps SHIFT so the next MSB follows with no gap.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = i_in_data;
                    w_last_nxt  = i_in_last;
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                w_idx_nxt   = IDX_TOP;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (!w_final_bit) begin
                    w_shift_nxt = {r_shift[W-2:0], 1'b0};
                    w_idx_nxt   = r_idx - IDX_W'(1);
                end else if (r_last) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_accept) begin
                    w_shift_nxt = i_in_data;
                    w_last_nxt  = i_in_last;
                    w_idx_nxt   = IDX_TOP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_accept) begin
                    w_shift_nxt = i_in_data;
                    w_last_nxt  = i_in_last;
                    w_idx_nxt   = IDX_TOP;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Detector-facing outputs are registered from the next state, so they line up
    // with the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_det_clr <= 1'b0;
            r_det_vld <= 1'b0;
            r_det_x   <= 1'b0;
            r_done    <= 1'b0;
            r_vld_d   <= 1'b0;
        end else begin
            r_det_clr <= (w_state_nxt == S_CLR);
            r_det_vld <= (w_state_nxt == S_SHIFT);
            r_det_x   <= (w_state_nxt == S_SHIFT) && w_shift_nxt[W-1];
            r_done    <= (w_state_nxt == S_DONE);
            r_vld_d   <= r_det_vld;
        end
    end

    // det_z is Moore and lags its bit by one cycle, hence qualification by r_vld_d.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_count <= '0;
        end else if (r_state == S_CLR) begin
            r_hit_count <= '0;
        end else if (r_vld_d && i_det_z && (r_hit_count != CNT_MAX)) begin
            r_hit_count <= r_hit_count + CNT_W'(1);
        end
    end

    assign o_in_ready  = w_ready;
    assign o_det_clr   = r_det_clr;
    assign o_det_vld   = r_det_vld;
    assign o_det_x     = r_det_x;
    assign o_hit_count = r_hit_count;
    assign o_done      = r_done;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_seqdet_ctrl.sv
// Bench for seqdet_ctrl: a vector table for one frame, scripted multi-word frames,
// and random frames checked against a bit-stream and popcount model.
module tb_seqdet_ctrl;
    localparam int W       = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int MAX_CYC = 600;

    logic             clk = 1'b0;
    logic             rstN;
    logic             inValid;
    logic [W-1:0]     inData;
    logic             inLast;
    logic             inReady;
    logic             detClr;
    logic             detVld;
    logic             detX;
    logic             detZ;
    logic [CNT_W-1:0] hitCount;
    logic             done;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic         last;
        logic [13:0]  exp;
    } vec_t;
    vec_t vecs[13];

    typedef struct {
        logic b;
        logic endOfFrame;
    } bit_t;
    bit_t expBits[$];
    int   frameOnes = 0;
    logic pendClr   = 1'b0;
    int   doneIn    = 0;

    logic [W-1:0] scrWords[64];
    int           scrStart[64];
    logic         doneSeen;
    int           doneCycle, vldCount, firstVld, lastVld;
    int           readyCycles, readyAtVld, waitCycles, clrCount, hitAtDone;

    seqdet_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_in_valid  (inValid),
        .i_in_data   (inData),
        .i_in_last   (inLast),
        .o_in_ready  (inReady),
        .o_det_clr   (detClr),
        .o_det_vld   (detVld),
        .o_det_x     (detX),
        .i_det_z     (detZ),
        .o_hit_count (hitCount),
        .o_done      (done),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Detector stand-in: every transmitted 1 is a hit one cycle later.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) detZ <= 1'b0;
        else       detZ <= detX & detVld;
    end

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic l);
        inValid = v;
        inData  = d;
        inLast  = l;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [13:0] actualOut();
        return {inReady, detClr, detVld, detX, done, busy, hitCount};
    endfunction

    function automatic logic [13:0] mkExp(input logic rdy, input logic clr, input logic vld,
                                          input logic x, input logic dn, input logic bsy, input int hit);
        return {rdy, clr, vld, x, dn, bsy, CNT_W'(hit)};
    endfunction

    // Stream model: accepted words queue their bits MSB-first; done is due two
    // cycles after the frame's final bit, carrying the saturated popcount.
    always @(negedge clk) begin
        bit_t e;
        logic expDone;
        int   expHit;
        #2;
        if (!rstN) begin
            expBits.delete();
            frameOnes = 0;
            pendClr   = 1'b0;
            doneIn    = 0;
        end else begin
            if (pendClr || detClr) checkOutput("mon_clr", detClr, pendClr);
            pendClr = 1'b0;
            expDone = (doneIn == 1);
            if (doneIn > 0) doneIn--;
            if (expDone || done) checkOutput("mon_done", done, expDone);
            if (expDone) begin
                expHit = (frameOnes > CNT_MAX) ? CNT_MAX : frameOnes;
                checkOutput("mon_hit", hitCount, expHit);
            end
            if (detVld) begin
                if (expBits.size() == 0) begin
                    checkOutput("mon_vld_unexpected", detVld, 1'b0);
                end else begin
                    e = expBits.pop_front();
                    checkOutput("mon_x", detX, e.b);
                    if (e.endOfFrame) doneIn = 2;
                end
            end
            if (inValid && inReady) begin
                if (!busy) begin
                    frameOnes = 0;
                    pendClr   = 1'b1;
                end
                frameOnes += $countones(inData);
                for (int k = W - 1; k >= 0; k--) begin
                    e.b          = inData[k];
                    e.endOfFrame = inLast && (k == 0);
                    expBits.push_back(e);
                end
            end
        end
    end

    // Presents scrWords[j] from cycle scrStart[j] until accepted; gathers statistics
    // until done. Cycle 0 is the first cycle the script runs.
    task automatic runScript(input int n);
        int j;
        j           = 0;
        doneSeen    = 1'b0;
        doneCycle   = -1;
        vldCount    = 0;
        firstVld    = -1;
        lastVld     = -1;
        readyCycles = 0;
        readyAtVld  = -1;
        waitCycles  = 0;
        clrCount    = 0;
        hitAtDone   = -1;
        for (int i = 0; i < MAX_CYC && !doneSeen; i++) begin
            @(negedge clk);
            if (j < n && i >= scrStart[j]) applyStimulus(1'b1, scrWords[j], j == n - 1);
            else                           applyStimulus(1'b0, W'($urandom), 1'($urandom));
            #1;
            if (detVld) begin
                vldCount++;
                if (vldCount == 1) firstVld = i;
                lastVld = i;
            end
            if (i > 0 && busy && inReady) begin
                readyCycles++;
                if (detVld) readyAtVld = vldCount;
            end
            if (busy && inReady && !detVld) waitCycles++;
            if (detClr) clrCount++;
            if (done) begin
                doneSeen  = 1'b1;
                doneCycle = i;
                hitAtDone = hitCount;
            end
            if (inValid && inReady) j++;
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("script_done_seen", doneSeen, 1'b1);
    endtask

    initial begin
        logic [W-1:0] a5;
        int           hitTab[8];
        int           n;
        int           ones;

        a5     = 8'hA5;
        hitTab = '{0, 0, 1, 1, 2, 2, 2, 3};
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, mkExp(1, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, mkExp(0, 1, 0, 0, 0, 1, 0)};
        for (int k = 0; k < 8; k++)
            vecs[2 + k] = '{1'b1, W'($urandom), 1'($urandom), mkExp(0, 0, 1, a5[7 - k], 0, 1, hitTab[k])};
        vecs[10] = '{1'b1, W'($urandom), 1'b0, mkExp(0, 0, 0, 0, 0, 1, 3)};
        vecs[11] = '{1'b1, W'($urandom), 1'b1, mkExp(0, 0, 0, 0, 1, 1, 4)};
        vecs[12] = '{1'b0, 8'h00, 1'b0, mkExp(1, 0, 0, 0, 0, 0, 4)};

        rstN = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #12;
        checkOutput("reset_state", actualOut(), mkExp(1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rstN = 1'b1;

        // Single 0xA5 frame, with in_data churning while in_ready is low.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].last);
            #1;
            checkOutput($sformatf("vec%0d", i), actualOut(), vecs[i].exp);
        end

        scrWords[0] = 8'hFF; scrStart[0] = 0;
        scrWords[1] = 8'h0F; scrStart[1] = 0;
        runScript(2);
        checkOutput("b2b_vld_count", vldCount, 16);
        checkOutput("b2b_first_bit", firstVld, 2);
        checkOutput("b2b_vld_span", lastVld - firstVld, 15);
        checkOutput("b2b_ready_cycles", readyCycles, 1);
        checkOutput("b2b_ready_bit", readyAtVld, 8);
        checkOutput("b2b_clr_count", clrCount, 1);
        checkOutput("b2b_done_cycle", doneCycle, 19);
        checkOutput("b2b_hit", hitAtDone, 12);

        scrWords[0] = 8'h80; scrStart[0] = 0;
        scrWords[1] = 8'h01; scrStart[1] = 14;
        runScript(2);
        checkOutput("gap_wait_cycles", waitCycles, 5);
        checkOutput("gap_ready_cycles", readyCycles, 6);
        checkOutput("gap_clr_count", clrCount, 1);
        checkOutput("gap_vld_count", vldCount, 16);
        checkOutput("gap_done_cycle", doneCycle, 24);
        checkOutput("gap_hit", hitAtDone, 2);

        for (int j = 0; j < 40; j++) begin
            scrWords[j] = 8'hFF;
            scrStart[j] = 0;
        end
        runScript(40);
        checkOutput("sat_vld_count", vldCount, 320);
        checkOutput("sat_done_cycle", doneCycle, 323);
        checkOutput("sat_hit", hitAtDone, CNT_MAX);

        // Abandon a 0xC3 frame during its fourth bit.
        @(negedge clk);
        applyStimulus(1'b1, 8'hC3, 1'b0);
        #1;
        checkOutput("rst_accept_ready", inReady, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, W'($urandom), 1'b0);
        end
        #1;
        checkOutput("rst_pre_state", {detVld, hitCount}, {1'b1, 8'd2});
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rst_async", actualOut(), mkExp(1, 0, 0, 0, 0, 0, 0));
        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_held", actualOut(), mkExp(1, 0, 0, 0, 0, 0, 0));
        rstN = 1'b1;
        scrWords[0] = 8'h03; scrStart[0] = 0;
        runScript(1);
        checkOutput("rst_after_done_cycle", doneCycle, 11);
        checkOutput("rst_after_hit", hitAtDone, 2);

        for (int f = 0; f < 6; f++) begin
            n    = $urandom_range(1, 4);
            ones = 0;
            for (int j = 0; j < n; j++) begin
                scrWords[j] = W'($urandom);
                ones += $countones(scrWords[j]);
                scrStart[j] = (j == 0) ? int'($urandom_range(0, 3))
                                       : scrStart[j - 1] + int'($urandom_range(0, 12));
            end
            runScript(n);
            checkOutput($sformatf("rand%0d_vld_count", f), vldCount, n * W);
            checkOutput($sformatf("rand%0d_hit", f), hitAtDone, ones);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
